// File: rtl/csrs_pkg.sv
// Shared definitions for the CSR read-modify-write master: operation and
// state encodings, the read-only address prefix and the default timeout.
package csrs_pkg;

  typedef enum logic [1:0] {
    OP_RW   = 2'b00,
    OP_RS   = 2'b01,
    OP_RC   = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_REQ  = 2'b01,
    RD_WAIT = 2'b10,
    RESP    = 2'b11
  } state_t;

  // CSR addresses whose top two bits equal this prefix are read-only.
  localparam logic [1:0] RO_PREFIX = 2'b11;

  localparam int TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/csrs_rmw_master.sv
// CSR read-modify-write master. Takes one CSR instruction request from the
// pipeline, performs the optional read of the old value, computes the new
// value (RW/RS/RC) and issues the optional write, then returns a single
// response pulse. Illegal requests and read timeouts return an error.
module csrs_rmw_master
  import csrs_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [1:0]  REQ_OP,
  input  logic [11:0] REQ_ADDR,
  input  logic [31:0] REQ_SRC,
  input  logic        REQ_RD_EN,
  input  logic        REQ_WR_EN,
  output logic        RESP_VALID,
  output logic [31:0] RESP_RDATA,
  output logic        RESP_ERR,
  output logic        RDEN,
  output logic [11:0] RADDR,
  input  logic        RVALID,
  input  logic [31:0] RDATA,
  output logic        WREN,
  output logic [11:0] WADDR,
  output logic [31:0] WDATA
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  op_t              op_q;
  logic [11:0]      addr_q;
  logic [31:0]      src_q;
  logic             wr_en_q;
  logic [CNT_W-1:0] wait_cnt;

  logic             accept;
  logic             req_illegal;
  logic             req_read;
  logic [31:0]      new_val;

  // Classify the incoming request so the IDLE branch can pick its path in one cycle.
  always_comb begin
    accept      = REQ_VALID & REQ_READY;
    req_illegal = (REQ_OP == OP_RSVD) |
                  (REQ_WR_EN & (REQ_ADDR[11:10] == RO_PREFIX));
    req_read    = REQ_RD_EN |
                  (REQ_WR_EN & ((REQ_OP == OP_RS) | (REQ_OP == OP_RC)));
  end

  // New CSR value from the old value arriving on RDATA and the latched operand.
  always_comb begin
    new_val = src_q;
    case (op_q)
      OP_RS:   new_val = RDATA | src_q;
      OP_RC:   new_val = RDATA & ~src_q;
      default: new_val = src_q;
    endcase
  end

  // Transaction FSM; every output is a register so strobes are glitch-free pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      op_q       <= OP_RW;
      addr_q     <= '0;
      src_q      <= '0;
      wr_en_q    <= 1'b0;
      wait_cnt   <= '0;
      REQ_READY  <= 1'b1;
      RESP_VALID <= 1'b0;
      RESP_RDATA <= '0;
      RESP_ERR   <= 1'b0;
      RDEN       <= 1'b0;
      RADDR      <= '0;
      WREN       <= 1'b0;
      WADDR      <= '0;
      WDATA      <= '0;
    end else begin
      RDEN       <= 1'b0;
      WREN       <= 1'b0;
      RESP_VALID <= 1'b0;
      RESP_ERR   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= op_t'(REQ_OP);
            addr_q    <= REQ_ADDR;
            src_q     <= REQ_SRC;
            wr_en_q   <= REQ_WR_EN;
            REQ_READY <= 1'b0;
            if (req_illegal) begin
              RESP_VALID <= 1'b1;
              RESP_ERR   <= 1'b1;
              RESP_RDATA <= '0;
              state      <= RESP;
            end else if (req_read) begin
              RDEN  <= 1'b1;
              RADDR <= REQ_ADDR;
              state <= RD_REQ;
            end else begin
              if (REQ_WR_EN) begin
                WREN  <= 1'b1;
                WADDR <= REQ_ADDR;
                WDATA <= REQ_SRC;
              end
              RESP_VALID <= 1'b1;
              RESP_RDATA <= '0;
              state      <= RESP;
            end
          end
        end
        RD_REQ: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (RVALID) begin
            RESP_VALID <= 1'b1;
            RESP_RDATA <= RDATA;
            if (wr_en_q) begin
              WREN  <= 1'b1;
              WADDR <= addr_q;
              WDATA <= new_val;
            end
            state <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            RESP_VALID <= 1'b1;
            RESP_ERR   <= 1'b1;
            RESP_RDATA <= '0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          REQ_READY <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          REQ_READY <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csrs_rmw_master.sv
// Self-checking bench for csrs_rmw_master. A transaction-level model predicts
// in which cycle after the accept edge each strobe and the response appear,
// and with which values; a responder inside the bench answers RDEN after a
// chosen latency (or never).
module tb_csrs_rmw_master;

  localparam int TIMEOUT = 16;
  localparam int WINDOW  = TIMEOUT + 8;
  localparam int SILENT  = 1000;

  logic        CLK;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [1:0]  REQ_OP;
  logic [11:0] REQ_ADDR;
  logic [31:0] REQ_SRC;
  logic        REQ_RD_EN;
  logic        REQ_WR_EN;
  logic        RESP_VALID;
  logic [31:0] RESP_RDATA;
  logic        RESP_ERR;
  logic        RDEN;
  logic [11:0] RADDR;
  logic        RVALID;
  logic [31:0] RDATA;
  logic        WREN;
  logic [11:0] WADDR;
  logic [31:0] WDATA;

  int errors = 0;
  int checks = 0;

  csrs_rmw_master #(.TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ_VALID  (REQ_VALID),
    .REQ_READY  (REQ_READY),
    .REQ_OP     (REQ_OP),
    .REQ_ADDR   (REQ_ADDR),
    .REQ_SRC    (REQ_SRC),
    .REQ_RD_EN  (REQ_RD_EN),
    .REQ_WR_EN  (REQ_WR_EN),
    .RESP_VALID (RESP_VALID),
    .RESP_RDATA (RESP_RDATA),
    .RESP_ERR   (RESP_ERR),
    .RDEN       (RDEN),
    .RADDR      (RADDR),
    .RVALID     (RVALID),
    .RDATA      (RDATA),
    .WREN       (WREN),
    .WADDR      (WADDR),
    .WDATA      (WDATA)
  );

  // Free-running clock, 10 time units per period.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Guard against a runaway simulation.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One complete transaction: drive the request, play the responder with read
  // latency lat (RVALID lat cycles after the RDEN cycle), record what the DUT
  // does in each cycle after the accept edge, and compare with the model.
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [11:0] addr, input logic [31:0] src,
                               input logic rd, input logic wr,
                               input logic [31:0] old, input int lat);
    bit          illegal, reads, timedOut;
    int          expRdenCyc, expWrenCyc, expRespCyc;
    logic [31:0] expWdata, expRdata;
    logic        expErr;
    int          rdenCnt, wrenCnt, respCnt;
    int          rdenCyc, wrenCyc, respCyc;
    logic [11:0] raddrObs, waddrObs;
    logic [31:0] wdataObs, rdataObs;
    logic        errObs;

    // Model: what the CSR instruction should do.
    illegal    = (op == 2'b11) || (wr && addr[11:10] == 2'b11);
    reads      = !illegal && (rd || (wr && op != 2'b00));
    timedOut   = reads && (lat < 1 || lat > TIMEOUT);
    expRdenCyc = reads ? 1 : -1;
    expRespCyc = !reads ? 1 : (timedOut ? 2 + TIMEOUT : 2 + lat);
    expErr     = illegal || timedOut;
    expRdata   = (reads && !timedOut) ? old : 32'h0;
    expWrenCyc = (!illegal && wr && !timedOut) ? expRespCyc : -1;
    case (op)
      2'b01:   expWdata = old | src;
      2'b10:   expWdata = old & ~src;
      default: expWdata = src;
    endcase

    @(negedge CLK);
    checkOutput({tag, ".ready_before"}, 32'(REQ_READY), 32'd1);
    REQ_VALID = 1'b1;
    REQ_OP    = op;
    REQ_ADDR  = addr;
    REQ_SRC   = src;
    REQ_RD_EN = rd;
    REQ_WR_EN = wr;
    @(posedge CLK);

    rdenCnt = 0; wrenCnt = 0; respCnt = 0;
    rdenCyc = -1; wrenCyc = -1; respCyc = -1;
    raddrObs = '0; waddrObs = '0; wdataObs = '0; rdataObs = '0; errObs = 1'b0;
    for (int k = 1; k <= WINDOW; k++) begin
      @(negedge CLK);
      if (RDEN === 1'b1) begin
        rdenCnt++;
        if (rdenCyc < 0) begin rdenCyc = k; raddrObs = RADDR; end
      end
      if (WREN === 1'b1) begin
        wrenCnt++;
        if (wrenCyc < 0) begin wrenCyc = k; waddrObs = WADDR; wdataObs = WDATA; end
      end
      if (RESP_VALID === 1'b1) begin
        respCnt++;
        if (respCyc < 0) begin respCyc = k; rdataObs = RESP_RDATA; errObs = RESP_ERR; end
      end
      // Responder: one RVALID pulse lat cycles after the observed RDEN cycle.
      if (rdenCyc >= 0 && k == rdenCyc + lat) begin
        RVALID = 1'b1;
        RDATA  = old;
      end else begin
        RVALID = 1'b0;
        RDATA  = $urandom;
      end
      // Keep pushing scrambled requests while busy; they must be ignored.
      if (respCyc >= 0) begin
        REQ_VALID = 1'b0;
      end else begin
        REQ_OP    = 2'($urandom);
        REQ_ADDR  = 12'($urandom);
        REQ_SRC   = $urandom;
        REQ_RD_EN = 1'($urandom);
        REQ_WR_EN = 1'($urandom);
      end
    end
    REQ_VALID = 1'b0;
    RVALID    = 1'b0;

    checkOutput({tag, ".rden_count"}, 32'(rdenCnt), reads ? 32'd1 : 32'd0);
    checkOutput({tag, ".rden_cycle"}, 32'(rdenCyc), 32'(expRdenCyc));
    if (reads) checkOutput({tag, ".raddr"}, 32'(raddrObs), 32'(addr));
    checkOutput({tag, ".wren_count"}, 32'(wrenCnt), (expWrenCyc > 0) ? 32'd1 : 32'd0);
    checkOutput({tag, ".wren_cycle"}, 32'(wrenCyc), 32'(expWrenCyc));
    if (expWrenCyc > 0) begin
      checkOutput({tag, ".waddr"}, 32'(waddrObs), 32'(addr));
      checkOutput({tag, ".wdata"}, wdataObs, expWdata);
    end
    checkOutput({tag, ".resp_count"}, 32'(respCnt), 32'd1);
    checkOutput({tag, ".resp_cycle"}, 32'(respCyc), 32'(expRespCyc));
    checkOutput({tag, ".resp_rdata"}, rdataObs, expRdata);
    checkOutput({tag, ".resp_err"}, 32'(errObs), 32'(expErr));
    checkOutput({tag, ".ready_after"}, 32'(REQ_READY), 32'd1);
  endtask

  // Directed steps followed by randomized transactions.
  initial begin
    logic [1:0]  rop;
    logic [11:0] raddr;
    logic        rrd, rwr;
    int          rlat, pulses;

    RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = 2'b00; REQ_ADDR = '0; REQ_SRC = '0;
    REQ_RD_EN = 1'b0; REQ_WR_EN = 1'b0; RVALID = 1'b0; RDATA = '0;
    repeat (2) @(negedge CLK);
    checkOutput("reset.ready",      32'(REQ_READY),  32'd1);
    checkOutput("reset.resp_valid", 32'(RESP_VALID), 32'd0);
    checkOutput("reset.resp_err",   32'(RESP_ERR),   32'd0);
    checkOutput("reset.resp_rdata", RESP_RDATA,      32'd0);
    checkOutput("reset.rden",       32'(RDEN),       32'd0);
    checkOutput("reset.wren",       32'(WREN),       32'd0);
    checkOutput("reset.addrs",      {8'd0, RADDR, WADDR}, 32'd0);
    checkOutput("reset.wdata",      WDATA,           32'd0);
    RST = 1'b0;

    $display("[TB] directed transactions");
    applyStimulus("rs_basic",   2'b01, 12'h300, 32'h8,        1, 1, 32'h1800, 1);
    applyStimulus("rc_basic",   2'b10, 12'h300, 32'hFF,       1, 1, 32'h1234, 1);
    applyStimulus("rs_nowrite", 2'b01, 12'h305, 32'h0,        1, 0, 32'hCAFE0001, 2);
    applyStimulus("rw_wronly",  2'b00, 12'h340, 32'hDEADBEEF, 0, 1, 32'h0, 1);
    applyStimulus("wr_ro",      2'b00, 12'hC00, 32'h55,       0, 1, 32'h0, 1);
    applyStimulus("op_rsvd",    2'b11, 12'h300, 32'h55,       1, 0, 32'h0, 1);
    applyStimulus("rd_ro",      2'b01, 12'hC00, 32'h0,        1, 0, 32'h600D, 1);
    applyStimulus("timeout",    2'b01, 12'h301, 32'h3,        1, 1, 32'h77, SILENT);
    applyStimulus("rv_on_edge", 2'b10, 12'h302, 32'hF0,       1, 1, 32'hABCD, TIMEOUT);
    applyStimulus("rv_late",    2'b00, 12'h303, 32'h12,       1, 1, 32'h99, TIMEOUT + 1);
    applyStimulus("rv_in_rdreq",2'b01, 12'h304, 32'h1,        1, 1, 32'h42, 0);

    $display("[TB] RVALID while idle");
    @(negedge CLK);
    RVALID = 1'b1; RDATA = 32'h12345678;
    pulses = 0;
    repeat (3) begin
      @(negedge CLK);
      if (RESP_VALID === 1'b1 || WREN === 1'b1) pulses++;
    end
    RVALID = 1'b0;
    checkOutput("idle_rvalid.pulses", 32'(pulses), 32'd0);

    $display("[TB] reset during RD_WAIT");
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_OP = 2'b01; REQ_ADDR = 12'h310; REQ_SRC = 32'h4;
    REQ_RD_EN = 1'b1; REQ_WR_EN = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1;
    checkOutput("midrst.ready",      32'(REQ_READY),  32'd1);
    checkOutput("midrst.resp_valid", 32'(RESP_VALID), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RVALID = 1'b1; RDATA = 32'hBAD0BAD0;
    pulses = 0;
    repeat (4) begin
      @(negedge CLK);
      RVALID = 1'b0;
      if (RESP_VALID === 1'b1 || WREN === 1'b1) pulses++;
    end
    checkOutput("midrst.late_rvalid", 32'(pulses), 32'd0);
    checkOutput("midrst.ready_after", 32'(REQ_READY), 32'd1);
    applyStimulus("after_rst", 2'b01, 12'h310, 32'h4, 1, 1, 32'h1, 1);

    $display("[TB] random transactions");
    for (int i = 0; i < 24; i++) begin
      rop   = 2'($urandom_range(0, 3));
      raddr = ($urandom_range(0, 3) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom);
      rrd   = 1'($urandom);
      rwr   = (rop == 2'b00) ? 1'b1 : 1'($urandom);
      case ($urandom_range(0, 6))
        0:       rlat = 0;
        1:       rlat = 1;
        2:       rlat = 2;
        3:       rlat = 5;
        4:       rlat = TIMEOUT;
        5:       rlat = TIMEOUT + 1;
        default: rlat = SILENT;
      endcase
      applyStimulus($sformatf("rand%0d", i), rop, raddr, $urandom, rrd, rwr, $urandom, rlat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csrs_rmw_master.md
CSRS_RMW_MASTER -- requirements
Module: csrs_rmw_master

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, meaning the cycles waited for RVALID before an error response.
REQ-002 SHALL provide ports, in order:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ_VALID  in  1  pipeline CSR request valid.
- REQ_READY  out  1  master can accept a request.
- REQ_OP  in  2  operation: 00 RW, 01 RS, 10 RC, 11 reserved.
- REQ_ADDR  in  12  CSR address.
- REQ_SRC  in  32  rs1/uimm operand.
- REQ_RD_EN  in  1  old value is needed (rd != 0).
- REQ_WR_EN  in  1  write is required (RW always; RS/RC when src reg != 0).
- RESP_VALID  out  1  one-cycle response pulse.
- RESP_RDATA  out  32  old CSR value; 0 when not read.
- RESP_ERR  out  1  illegal access or timeout, qualified by RESP_VALID.
- RDEN  out  1  CSR read strobe.
- RADDR  out  12  CSR read address.
- RVALID  in  1  CSR read data valid.
- RDATA  in  32  CSR read data.
- WREN  out  1  CSR write strobe.
- WADDR  out  12  CSR write address.
- WDATA  out  32  CSR write data.

Function
REQ-003 SHALL implement states IDLE, RD_REQ, RD_WAIT, RESP; all outputs SHALL be registered.
REQ-004 REQ_READY SHALL be 1 only in IDLE; accept = REQ_VALID & REQ_READY.
REQ-005 On accept, SHALL latch OP/ADDR/SRC/RD_EN/WR_EN; a read SHALL occur if RD_EN, or if WR_EN and OP is RS or RC.
REQ-006 Illegal cases SHALL complete with no RDEN/WREN: OP=11, or WR_EN with ADDR[11:10]=11 (read-only). These SHALL give RESP_VALID=1, RESP_ERR=1 and RESP_RDATA=0 in cycle t+1 (accept edge t).
REQ-007 Write-only (RW, no read) SHALL drive WREN=1, WADDR=ADDR, WDATA=SRC, RESP_VALID=1 and RESP_RDATA=0, all in cycle t+1.
REQ-008 Read path timing:
- RDEN=1 and RADDR=ADDR for exactly cycle t+1 (RD_REQ).
- Then RD_WAIT until RVALID=1 is sampled.
- At that edge, capture RDATA as old.
REQ-009 New value SHALL be: RW: SRC; RS: old | SRC; RC: old & ~SRC.
REQ-010 In the cycle after RVALID is sampled, SHALL assert RESP_VALID=1, RESP_RDATA=old and RESP_ERR=0. WREN=1 with WADDR=ADDR and WDATA=new SHALL also be asserted in that cycle only if WR_EN.
REQ-011 With a 1-cycle responder, the read/RMW response SHALL be in cycle t+3.
REQ-012 RD_WAIT SHALL count cycles. On reaching TIMEOUT without RVALID, SHALL give RESP_VALID=1, RESP_ERR=1, RESP_RDATA=0 and no WREN.
REQ-013 RVALID SHALL be ignored outside RD_WAIT. RVALID on the same edge as the timeout SHALL win (normal completion).
REQ-014 RDEN, WREN and RESP_VALID SHALL each be single-cycle pulses; the state SHALL return to IDLE after the response cycle. Back-to-back accept is possible one cycle after the response.
REQ-015 REQ_* inputs SHALL be ignored while not in IDLE.
REQ-016 RADDR/WADDR/WDATA SHALL hold their last values when strobes are low.

Reset
REQ-017 RST=1 SHALL asynchronously force IDLE, the timeout counter to 0, and every output to 0 except REQ_READY, which SHALL be 1.
REQ-018 Reset mid-operation SHALL abandon the transaction with no WREN and no RESP_VALID. An RVALID arriving after reset release SHALL be ignored.

Structure
REQ-019 Package csrs_pkg SHALL hold the OP encodings, the state encoding, the read-only address prefix 2'b11 and the TIMEOUT default.
REQ-020 SHALL be a single flat module with no sub-module; the RMW arithmetic is inline.

Verification
REQ-021 CSRRS with ADDR=0x300, SRC=0x8, RD/WR=1, responder RDATA=0x1800 -> RDEN at t+1; at t+3: WREN, WDATA=0x1808, RESP_RDATA=0x1800, ERR=0.
REQ-022 CSRRC with SRC=0xFF, old=0x1234 -> WDATA=0x1200. RS with WR_EN=0 -> RESP_RDATA=old and no WREN.
REQ-023 CSRRW with RD_EN=0, ADDR=0x340, SRC=0xDEADBEEF -> no RDEN; at t+1: WREN, WDATA=0xDEADBEEF, RESP_RDATA=0.
REQ-024 Write to 0xC00 or OP=11 -> RESP_ERR=1 at t+1, no RDEN/WREN. Read of 0xC00 with WR_EN=0 -> normal read.
REQ-025 Responder silent -> RESP_ERR=1 after TIMEOUT cycles in RD_WAIT. RVALID on the timeout edge -> normal response instead.
REQ-026 RST asserted in RD_WAIT, then late RVALID -> no WREN/RESP_VALID, REQ_READY=1; the next request completes normally.
